// File: rtl/data_mem_resp.sv
// rtl/data_mem_resp.sv - multi-cycle word data memory answering ALU load/store requests
//
// Accepts one request at a time, waits WAIT_CYCLES wait states, then commits
// the word access to an internal 2**ADDR_W x 32 array and presents the result
// on a valid/ready response channel.
//
// Optional build macro: DATA_MEM_BYTE_EN_EN adds req_be[3:0] byte enables.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   high in IDLE only
//   req_addr    in   32  byte address
//   req_wr      in   1   1 = store, 0 = load
//   req_wdata   in   32  store data
//   req_be      in   4   byte enables (DATA_MEM_BYTE_EN_EN builds only)
//   resp_valid  out  1   response present
//   resp_ready  in   1   consumer accepts response
//   resp_rdata  out  32  load data; 0 for stores and errors
//   resp_err    out  1   misaligned or out-of-range request

module data_mem_resp #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [31:0] req_wdata,
`ifdef DATA_MEM_BYTE_EN_EN
  input  logic [3:0]  req_be,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << ADDR_W;

  // The counter is loaded with the full wait-state count on accept and the
  // access commits on the edge after it reads zero, so a request accepted at
  // edge N shows resp_valid after edge N+WAIT_CYCLES+1 (WAIT_CYCLES=0 included).
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]        cnt;
  logic [ADDR_W-1:0] idx_q;
  logic              wr_q;
  logic              err_q;
  logic [31:0]       wdata_q;
  logic [3:0]        be_q;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              commit;
  logic              req_err;
  logic [3:0]        req_be_eff;
  logic [31:0]       lane_mask;

`ifdef DATA_MEM_BYTE_EN_EN
  assign req_be_eff = req_be;
`else
  assign req_be_eff = 4'hF;
`endif

  // Any set bit above the word index makes the request an error instead of
  // aliasing onto a lower word.
  assign req_err = (req_addr[1:0] != 2'b00) ||
                   ((req_addr >> (ADDR_W + 2)) != 32'd0);

  assign accept = req_valid && req_ready;

  // Gated by rst_n so a reset overlapping the commit edge never writes.
  assign commit = rst_n && (state == BUSY) && (cnt == 4'd0);

  assign lane_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      idx_q      <= '0;
      wr_q       <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= WAIT_INIT;
        idx_q   <= req_addr[ADDR_W+1:2];
        wr_q    <= req_wr;
        err_q   <= req_err;
        wdata_q <= req_wdata;
        be_q    <= req_be_eff;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        resp_valid <= 1'b1;
        resp_err   <= err_q;
        if (err_q || wr_q) begin
          resp_rdata <= 32'd0;
        end else begin
          resp_rdata <= mem[idx_q] & lane_mask;
        end
      end else if (state == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_rdata <= 32'd0;
      end
    end
  end

  // Array has no reset: contents are undefined until written.
  always_ff @(posedge clk) begin
    if (commit && wr_q && !err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) begin
          mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
